multicycle_controller: RTL and testbench

//  Main FSM and ALU decoder that sequence the multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main FSM and ALU decoder for the multicycle RV32I-subset datapath
// (lw, sw, R-type, I-type ALU, beq, jal).
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   op             instruction[6:0] from IR
//   funct3         instruction[14:12]
//   funct7b5       instruction[30]
//   Zero           ALU result == 0
//   PCWrite        PC register enable (PCUpdate | Branch & Zero)
//   AdrSrc         memory address select: 0=PC, 1=ALUOut
//   MemWrite       memory write strobe
//   IRWrite        IR/OldPC enable
//   RegWrite       register file write strobe
//   ResultSrc      00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA        00=PC, 01=OldPC, 10=rs1
//   ALUSrcB        00=rs2, 01=ImmExt, 10=const 4
//   ImmSrc         00=I, 01=S, 10=B, 11=J (decoded from op every cycle)
//   ALUControl     000 add, 001 sub, 010 and, 011 or, 101 slt
//   instr_done     one-cycle pulse on the final cycle of each instruction
//   illegal_instr  one-cycle pulse in DECODE for an unsupported opcode
//   state          current state encoding (debug)
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       done;
  } ctrl_t;

  // Moore output decode, applied to the next state so outputs are registered.
  function automatic ctrl_t ctrl_of(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.done = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      S_BEQ: begin
        c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; c.done = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   op_legal;

  always_comb begin
    op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  // Registered outputs hold FETCH values during reset; strobes are gated
  // with reset so nothing fires while it is asserted.
  always_comb begin
    PCWrite       = reset & (ctrl_q.pc_update | (ctrl_q.branch & Zero));
    IRWrite       = reset & ctrl_q.ir_write;
    RegWrite      = reset & ctrl_q.reg_write;
    MemWrite      = reset & ctrl_q.mem_write;
    instr_done    = reset & ctrl_q.done;
    illegal_instr = reset & (state_q == S_DECODE) & ~op_legal;
    AdrSrc        = ctrl_q.adr_src;
    ResultSrc     = ctrl_q.result_src;
    ALUSrcA       = ctrl_q.alu_src_a;
    ALUSrcB       = ctrl_q.alu_src_b;
    state         = state_q;
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (ctrl_q.alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, funct7b5, Zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  logic       rst_h, f7_h, zero_h;
  logic [6:0] op_h;
  logic [2:0] f3_h;
  logic       pcw_h, adr_h, memw_h, irw_h, regw_h, done_h, ill_h;
  logic [1:0] rsrc_h, srca_h, srcb_h, imm_h;
  logic [2:0] alu_h;
  logic [3:0] state_h;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .state(state)
  );

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .reset(rst_h), .op(op_h), .funct3(f3_h), .funct7b5(f7_h), .Zero(zero_h),
    .PCWrite(pcw_h), .AdrSrc(adr_h), .MemWrite(memw_h), .IRWrite(irw_h),
    .RegWrite(regw_h), .ResultSrc(rsrc_h), .ALUSrcA(srca_h), .ALUSrcB(srcb_h),
    .ImmSrc(imm_h), .ALUControl(alu_h), .instr_done(done_h),
    .illegal_instr(ill_h), .state(state_h)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: each instruction is a fixed walk through the named states.
  typedef struct packed {
    logic       pcupd, branch, adr, memw, irw, regw;
    logic [1:0] rsrc, srca, srcb;
  } mo_t;

  function automatic mo_t state_outputs(input logic [3:0] s);
    mo_t m;
    m = '0;
    case (s)
      4'd0:  begin m.pcupd = 1; m.irw = 1; m.rsrc = 2'b10; m.srcb = 2'b10; end
      4'd1:  begin m.srca = 2'b01; m.srcb = 2'b01; end
      4'd2:  begin m.srca = 2'b10; m.srcb = 2'b01; end
      4'd3:  m.adr = 1;
      4'd4:  begin m.rsrc = 2'b01; m.regw = 1; end
      4'd5:  begin m.adr = 1; m.memw = 1; end
      4'd6:  m.srca = 2'b10;
      4'd7:  m.regw = 1;
      4'd8:  begin m.srca = 2'b10; m.srcb = 2'b01; end
      4'd9:  begin m.srca = 2'b01; m.srcb = 2'b10; m.pcupd = 1; end
      4'd10: begin m.srca = 2'b10; m.branch = 1; end
      default: m = '0;
    endcase
    return m;
  endfunction

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, regw, memw, done, adr, ill;
    logic [1:0] imm, rsrc, srcb;
    logic [2:0] alu;
  } tr_t;

  tr_t        trace[$];
  int         m_pos = 0;
  logic [3:0] m_path[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) m_pos <= 0;
    else if (m_path.size() != 0) m_pos <= (m_pos + 1 >= m_path.size()) ? 0 : m_pos + 1;
  end

  // Single compare process: every falling edge, DUT against the reference.
  always @(negedge clk) begin : compare
    logic [3:0] es;
    mo_t        mo;
    logic       last, ill;
    logic [2:0] ealu;
    logic [1:0] eimm;
    if (reset !== 1'b1) begin
      check("rst_state", 32'(state), 32'd0);
      check("rst_strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal_instr}), 32'd0);
    end else begin
      if (m_pos == 0) begin
        case (op)
          LW:      m_path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
          SW:      m_path = '{4'd0, 4'd1, 4'd2, 4'd5};
          RT:      m_path = '{4'd0, 4'd1, 4'd6, 4'd7};
          IT:      m_path = '{4'd0, 4'd1, 4'd8, 4'd7};
          JAL:     m_path = '{4'd0, 4'd1, 4'd9, 4'd7};
          BEQ:     m_path = '{4'd0, 4'd1, 4'd10};
          default: m_path = '{4'd0, 4'd1};
        endcase
      end
      es   = m_path[m_pos];
      mo   = state_outputs(es);
      ill  = (m_path.size() == 2);
      last = (m_pos == m_path.size() - 1);
      ealu = 3'b000;
      if (es == 4'd6 || es == 4'd8) begin
        case (funct3)
          3'b000: ealu = (op == RT && funct7b5) ? 3'b001 : 3'b000;
          3'b010: ealu = 3'b101;
          3'b110: ealu = 3'b011;
          3'b111: ealu = 3'b010;
          default: ealu = 3'b000;
        endcase
      end else if (es == 4'd10) ealu = 3'b001;
      case (op)
        SW:      eimm = 2'b01;
        BEQ:     eimm = 2'b10;
        JAL:     eimm = 2'b11;
        default: eimm = 2'b00;
      endcase
      check("m_state", 32'(state), 32'(es));
      check("m_pcwrite", 32'(PCWrite), 32'(mo.pcupd | (mo.branch & Zero)));
      check("m_irwrite", 32'(IRWrite), 32'(mo.irw));
      check("m_regwrite", 32'(RegWrite), 32'(mo.regw));
      check("m_memwrite", 32'(MemWrite), 32'(mo.memw));
      check("m_adrsrc", 32'(AdrSrc), 32'(mo.adr));
      check("m_sels", 32'({ResultSrc, ALUSrcA, ALUSrcB}), 32'({mo.rsrc, mo.srca, mo.srcb}));
      check("m_immsrc", 32'(ImmSrc), 32'(eimm));
      check("m_aluctl", 32'(ALUControl), 32'(ealu));
      check("m_done", 32'(instr_done), 32'(last && !ill));
      check("m_illegal", 32'(illegal_instr), 32'(ill && es == 4'd1));
      trace.push_back('{state, PCWrite, IRWrite, RegWrite, MemWrite, instr_done, AdrSrc,
                        illegal_instr, ImmSrc, ResultSrc, ALUSrcB, ALUControl});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH (#1 after the edge), runs one instruction to the next FETCH.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int n;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    trace.delete();
    n = 0;
    do begin
      step();
      n++;
    end while (m_pos != 0 && n < 8);
    check("instr_bounded", 32'(m_pos), 32'd0);
  endtask

  task automatic check_path(input string name, input int len, input logic [39:0] exp_st);
    check({name, "_len"}, 32'(trace.size()), 32'(len));
    for (int i = 0; i < len && i < trace.size(); i++)
      check({name, "_state"}, 32'(trace[i].st), 32'(exp_st[(len-1-i)*4 +: 4]));
  endtask

  initial begin
    int cnt;
    reset = 1'b0; op = LW; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    rst_h = 1'b0; op_h = 7'b0000000; f3_h = '0; f7_h = 1'b0; zero_h = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_irwrite", 32'(IRWrite), 32'd0);
    reset = 1'b1;

    issue(LW, 3'b010, 1'b0, 1'b0);
    check_path("lw", 5, 40'h01234);
    if (trace.size() == 5) begin
      check("fetch_irwrite", 32'(trace[0].irw), 32'd1);
      check("fetch_pcwrite", 32'(trace[0].pcw), 32'd1);
      check("fetch_srcb", 32'(trace[0].srcb), 32'd2);
      check("fetch_rsrc", 32'(trace[0].rsrc), 32'd2);
      check("lw_adrsrc", 32'(trace[3].adr), 32'd1);
      for (int i = 0; i < 5; i++) begin
        check("lw_regwrite", 32'(trace[i].regw), 32'(i == 4));
        check("lw_done", 32'(trace[i].done), 32'(i == 4));
      end
    end

    issue(SW, 3'b010, 1'b0, 1'b0);
    check_path("sw", 4, 40'h0125);
    cnt = 0;
    foreach (trace[i]) cnt += int'(trace[i].memw) + 10 * int'(trace[i].regw);
    check("sw_memw_once_noregw", 32'(cnt), 32'd1);
    if (trace.size() == 4) begin
      check("sw_memw_state5", 32'(trace[3].memw), 32'd1);
      check("sw_immsrc", 32'(trace[1].imm), 32'd1);
    end

    issue(RT, 3'b000, 1'b1, 1'b0);
    check_path("rsub", 4, 40'h0167);
    if (trace.size() == 4) check("rsub_alu", 32'(trace[2].alu), 32'd1);
    issue(RT, 3'b111, 1'b0, 1'b0);
    if (trace.size() == 4) check("rand_alu", 32'(trace[2].alu), 32'd2);
    issue(IT, 3'b000, 1'b1, 1'b0);
    check_path("iadd", 4, 40'h0187);
    if (trace.size() == 4) check("iadd_alu", 32'(trace[2].alu), 32'd0);

    issue(BEQ, 3'b000, 1'b0, 1'b1);
    check_path("beq", 3, 40'h01A);
    if (trace.size() == 3) check("beq_taken_pcw", 32'(trace[2].pcw), 32'd1);
    issue(BEQ, 3'b000, 1'b0, 1'b0);
    if (trace.size() == 3) check("beq_not_pcw", 32'(trace[2].pcw), 32'd0);

    issue(JAL, 3'b000, 1'b0, 1'b0);
    check_path("jal", 4, 40'h0197);
    if (trace.size() == 4) check("jal_pcw", 32'(trace[2].pcw), 32'd1);

    issue(7'b0000000, 3'b000, 1'b0, 1'b0);
    check_path("ill_skip", 2, 40'h01);
    if (trace.size() == 2) check("ill_pulse", 32'(trace[1].ill), 32'd1);

    // Reset asserted mid-instruction while in MEMREAD.
    op = LW;
    repeat (3) step();
    check("mid_memread", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite, instr_done}), 32'd0);
    repeat (2) step();
    reset = 1'b1;

    repeat (300) begin
      logic [6:0] o;
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = JAL;
        5: o = BEQ;
        default: o = 7'($urandom);
      endcase
      issue(o, 3'($urandom), 1'($urandom), 1'($urandom));
    end

    // Halting variant: illegal opcode parks the FSM.
    step();
    rst_h = 1'b1;
    #1;
    check("h_fetch_state", 32'(state_h), 32'd0);
    check("h_fetch_irw", 32'(irw_h), 32'd1);
    step();
    check("h_decode_state", 32'(state_h), 32'd1);
    check("h_illegal", 32'(ill_h), 32'd1);
    step();
    check("h_halt_state", 32'(state_h), 32'd11);
    check("h_illegal_once", 32'(ill_h), 32'd0);
    repeat (10) begin
      step();
      check("h_hold_state", 32'(state_h), 32'd11);
      check("h_hold_strobes", 32'({pcw_h, irw_h, regw_h, memw_h, done_h, ill_h}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
